// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 frame scheduler.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package ws2812_pkg;

   // Width of one GRB pixel word
   localparam int PIX_W = 24;

   // Frame scheduler states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SEND,
      ST_DRAIN,
      ST_LATCH
   } state_t;

   // Clock cycles between two frame ticks
   function automatic int frame_cycles(input int clk_hz, input int frame_hz);
      return clk_hz / frame_hz;
   endfunction

   // Clock cycles the line is held idle after the last bit
   function automatic int latch_cycles(input int clk_hz, input int latch_us);
      return (clk_hz / 1_000_000) * latch_us;
   endfunction

endpackage

// File: rtl/ws2812_dim.sv
// Per-channel brightness scaler: chan_out = (chan_in * (level + 1)) >> 8.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the result is captured.
module ws2812_dim (
   input  logic [7:0] chan_in,
   input  logic [7:0] level,
   output logic [7:0] chan_out
);

   logic [8:0]  gain;
   logic [15:0] prod;

   // level+1 makes 255 an exact identity and 0 a full blank; the product
   // never exceeds 255*256, so 16 bits hold it without overflow
   always_comb begin
      gain     = {1'b0, level} + 9'd1;
      prod     = {8'd0, chan_in} * {7'd0, gain};
      chan_out = 8'(prod >> 8);
   end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler: on each enabled frame tick, streams NUM_LEDS GRB words to ws2812_tx, then holds a latch gap.
// Latency: tick -> pix_rd 1 cycle, pix_rd -> tx_valid 2 cycles, 3 cycles per LED minimum.
// Backpressure: tx_data/tx_valid held until tx_ready; ticks outside IDLE are dropped with an overrun pulse.
// Optional global dimming is compiled in with WS2812_BRIGHTNESS_EN.
module ws2812_frame_ctrl
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int CLK_HZ   = 48_000_000,
   parameter int FRAME_HZ = 60,
   parameter int LATCH_US = 80,
   localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             pix_rd,
   output logic [AW-1:0]    pix_addr,
   input  logic [PIX_W-1:0] pix_data,
   output logic [PIX_W-1:0] tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic             tx_idle,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
`ifdef WS2812_BRIGHTNESS_EN
   ,
   input  logic [7:0]       brightness
`endif
);

   localparam int FRAME_CYCLES = frame_cycles(CLK_HZ, FRAME_HZ);
   localparam int LATCH_CYCLES = latch_cycles(CLK_HZ, LATCH_US);
   localparam int TW           = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int LW           = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_CYCLES - 1);
   localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
   localparam logic [AW-1:0] ADDR_LAST  = AW'(NUM_LEDS - 1);

   // ------------------------------------------------------------------
   // Word presented to the serializer in LOAD
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] load_word;

`ifdef WS2812_BRIGHTNESS_EN
   ws2812_dim u_dim_g (
      .chan_in  (pix_data[23:16]),
      .level    (brightness),
      .chan_out (load_word[23:16])
   );

   ws2812_dim u_dim_r (
      .chan_in  (pix_data[15:8]),
      .level    (brightness),
      .chan_out (load_word[15:8])
   );

   ws2812_dim u_dim_b (
      .chan_in  (pix_data[7:0]),
      .level    (brightness),
      .chan_out (load_word[7:0])
   );
`else
   assign load_word = pix_data;
`endif

   // ------------------------------------------------------------------
   // Free-running frame tick counter
   // ------------------------------------------------------------------
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   // Count 0..FRAME_CYCLES-1 regardless of state or enable; tick on wrap
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // Tick counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [AW-1:0]    pix_addr_q, pix_addr_d;
   logic             pix_rd_q, pix_rd_d;
   logic [PIX_W-1:0] tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic [LW-1:0]    latch_cnt_q, latch_cnt_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;

   // Next state and next values of every registered output
   always_comb begin
      state_d      = state_q;
      pix_addr_d   = pix_addr_q;
      pix_rd_d     = 1'b0;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      latch_cnt_d  = latch_cnt_q;
      frame_done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // a tick with enable low is ignored without any indication
            if (tick && enable) begin
               state_d    = ST_FETCH;
               pix_addr_d = '0;
               pix_rd_d   = 1'b1;
            end
         end

         ST_FETCH: begin
            // pix_data arrives one cycle after the read strobe
            state_d = ST_LOAD;
         end

         ST_LOAD: begin
            // the only place tx_data changes, so it is stable while valid
            tx_data_d  = load_word;
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
         end

         ST_SEND: begin
            if (tx_valid_q && tx_ready) begin
               tx_valid_d = 1'b0;
               if (pix_addr_q == ADDR_LAST) begin
                  state_d = ST_DRAIN;
               end else begin
                  pix_addr_d = pix_addr_q + AW'(1);
                  pix_rd_d   = 1'b1;
                  state_d    = ST_FETCH;
               end
            end
         end

         ST_DRAIN: begin
            // last word accepted, wait until it has left the shifter
            if (tx_idle) begin
               latch_cnt_d = '0;
               state_d     = ST_LATCH;
            end
         end

         ST_LATCH: begin
            if (latch_cnt_q == LATCH_LAST) begin
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               latch_cnt_d = latch_cnt_q + LW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);

      // Registered overrun must be high in the tick cycle itself, so look
      // one cycle ahead: tick_cnt_d/state_d are next cycle's counter/state
      overrun_d = (tick_cnt_d == TICK_LAST) && (state_d != ST_IDLE);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pix_addr_q   <= '0;
         pix_rd_q     <= 1'b0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         latch_cnt_q  <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_addr_q   <= pix_addr_d;
         pix_rd_q     <= pix_rd_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         latch_cnt_q  <= latch_cnt_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign pix_rd     = pix_rd_q;
   assign pix_addr   = pix_addr_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: 3 LEDs, 1000-cycle frame, 80-cycle latch.
// Inputs are driven and outputs sampled on the falling clock edge.
// Brightness checks are compiled in with WS2812_BRIGHTNESS_EN.
module tb_ws2812_frame_ctrl;

   localparam int NUM_LEDS = 3;
   localparam int CLK_HZ   = 1_000_000;
   localparam int FRAME_HZ = 1000;
   localparam int LATCH_US = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        pix_rd;
   logic [1:0]  pix_addr;
   logic [23:0] pix_data = 24'h0;
   logic [23:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        tx_idle = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        overrun;
`ifdef WS2812_BRIGHTNESS_EN
   logic [7:0]  brightness = 8'd255;
`endif

   logic [23:0] mem [0:NUM_LEDS-1];

   int n_checks = 0;
   int n_fail   = 0;

   // results of the most recent observe_frame call
   logic [23:0] words [0:15];
   int          nwords, n_rd, n_ovr, ovr_c, last_hs;
   logic        vld_log  [0:2047];
   logic [23:0] dat_log  [0:2047];
   logic        busy_log [0:2047];

   always #5 clk = ~clk;

   ws2812_frame_ctrl #(
      .NUM_LEDS (NUM_LEDS),
      .CLK_HZ   (CLK_HZ),
      .FRAME_HZ (FRAME_HZ),
      .LATCH_US (LATCH_US)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .pix_rd     (pix_rd),
      .pix_addr   (pix_addr),
      .pix_data   (pix_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_idle    (tx_idle),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
`ifdef WS2812_BRIGHTNESS_EN
      ,
      .brightness (brightness)
`endif
   );

   // pixel RAM with one cycle read latency
   always @(posedge clk) begin
      if (pix_rd) pix_data <= mem[pix_addr];
   end

   // step falling edges until pix_rd is seen; n = edges stepped, -1 on timeout
   task automatic wait_rd(input int budget, output int n);
      n = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (pix_rd) begin
            n = k;
            break;
         end
      end
   endtask

   // record one frame starting at the current (pix_rd) edge, cycle c=0;
   // tx_ready low for c in [rs,re), tx_idle low for c < ie, enable drops at c >= ed (ed<0: never)
   task automatic observe_frame(input int budget, input int rs, input int re, input int ie,
                                input int ed, output int done_c);
      nwords = 0; n_rd = 0; n_ovr = 0; ovr_c = -1; last_hs = -1; done_c = -1;
      for (int c = 0; c < budget; c++) begin
         tx_ready = !(c >= rs && c < re);
         tx_idle  = (c >= ie);
         if (ed >= 0 && c >= ed) enable = 1'b0;
         vld_log[c]  = tx_valid;
         dat_log[c]  = tx_data;
         busy_log[c] = busy;
         if (pix_rd) n_rd++;
         if (overrun) begin n_ovr++; ovr_c = c; end
         if (tx_valid && tx_ready) begin
            if (nwords < 16) words[nwords] = tx_data;
            nwords++;
            last_hs = c;
         end
         if (frame_done) begin
            done_c = c;
            break;
         end
         @(negedge clk);
      end
      tx_ready = 1'b1;
      tx_idle  = 1'b1;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; enable = 1'b1; tx_ready = 1'b1; tx_idle = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++; if (pix_rd !== 1'b0) begin n_fail++; $display("FAIL reset_pix_rd: got %b want 0", pix_rd); end
      n_checks++; if (pix_addr !== 2'd0) begin n_fail++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
      n_checks++; if (tx_data !== 24'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 000000", tx_data); end
      n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (frame_done !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: frame_done %b overrun %b want 0 0", frame_done, overrun); end
      rst = 1'b0;
      wait_rd(1100, n);
      n_checks++; if (n !== 1000) begin n_fail++; $display("FAIL first_pix_rd_delay: got %0d want 1000", n); end
      n_checks++; if (pix_addr !== 2'd0) begin n_fail++; $display("FAIL first_pix_addr: got %0d want 0", pix_addr); end
   endtask

   task automatic test_nominal();
      int d;
      observe_frame(300, -1, -1, 0, -1, d);
      n_checks++; if (nwords !== 3) begin n_fail++; $display("FAIL nom_word_count: got %0d want 3", nwords); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (words[i] !== mem[i]) begin n_fail++; $display("FAIL nom_word%0d: got %h want %h", i, words[i], mem[i]); end
      end
      n_checks++; if (n_rd !== 3) begin n_fail++; $display("FAIL nom_pix_rd_count: got %0d want 3", n_rd); end
      n_checks++; if (last_hs !== 8) begin n_fail++; $display("FAIL nom_last_handshake: got %0d want 8", last_hs); end
      n_checks++; if (d !== 90) begin n_fail++; $display("FAIL nom_frame_done_cycle: got %0d want 90", d); end
      if (d > 0) begin
         n_checks++; if (busy_log[d-1] !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_fall: before %b at_done %b want 1 0", busy_log[d-1], busy); end
      end
      n_checks++; if (n_ovr !== 0) begin n_fail++; $display("FAIL nom_overrun: got %0d pulses want 0", n_ovr); end
      @(negedge clk);
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL nom_frame_done_width: got %b want 0", frame_done); end
   endtask

   task automatic test_backpressure();
      int n, d;
      wait_rd(1100, n);
      n_checks++; if (n !== 909) begin n_fail++; $display("FAIL bp_frame_start: got %0d want 909", n); end
      observe_frame(400, 5, 15, 0, -1, d);
      for (int c = 5; c <= 15; c++) begin
         n_checks++; if (vld_log[c] !== 1'b1 || dat_log[c] !== 24'h445566) begin n_fail++; $display("FAIL bp_hold_c%0d: valid %b data %h want 1 445566", c, vld_log[c], dat_log[c]); end
      end
      n_checks++; if (n_rd !== 3) begin n_fail++; $display("FAIL bp_pix_rd_count: got %0d want 3", n_rd); end
      n_checks++; if (nwords !== 3 || words[1] !== 24'h445566 || words[2] !== 24'h778899) begin n_fail++; $display("FAIL bp_words: n %0d w1 %h w2 %h want 3 445566 778899", nwords, words[1], words[2]); end
      n_checks++; if (d !== 100) begin n_fail++; $display("FAIL bp_frame_done_cycle: got %0d want 100", d); end
   endtask

   task automatic test_overrun();
      int n, d;
      wait_rd(1100, n);
      n_checks++; if (n !== 900) begin n_fail++; $display("FAIL ovr_frame_start: got %0d want 900", n); end
      observe_frame(1600, -1, -1, 1200, -1, d);
      n_checks++; if (n_ovr !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", n_ovr); end
      n_checks++; if (ovr_c !== 999) begin n_fail++; $display("FAIL ovr_cycle: got %0d want 999", ovr_c); end
      n_checks++; if (n_rd !== 3) begin n_fail++; $display("FAIL ovr_no_second_frame: pix_rd %0d want 3", n_rd); end
      n_checks++; if (d !== 1281) begin n_fail++; $display("FAIL ovr_frame_done_cycle: got %0d want 1281", d); end
      wait_rd(1100, n);
      n_checks++; if (n !== 719) begin n_fail++; $display("FAIL ovr_next_frame_start: got %0d want 719", n); end
      observe_frame(300, -1, -1, 0, -1, d);
      n_checks++; if (d !== 90 || n_ovr !== 0) begin n_fail++; $display("FAIL ovr_recovery_frame: done %0d overrun %0d want 90 0", d, n_ovr); end
   endtask

   task automatic test_enable();
      int n, d, rd_cnt, ov_cnt;
      enable = 1'b0; rd_cnt = 0; ov_cnt = 0;
      for (int k = 0; k < 1100; k++) begin
         @(negedge clk);
         if (pix_rd) rd_cnt++;
         if (overrun) ov_cnt++;
      end
      n_checks++; if (rd_cnt !== 0 || ov_cnt !== 0) begin n_fail++; $display("FAIL en_low_tick: pix_rd %0d overrun %0d want 0 0", rd_cnt, ov_cnt); end
      enable = 1'b1;
      wait_rd(1100, n);
      n_checks++; if (n !== 810) begin n_fail++; $display("FAIL en_frame_start: got %0d want 810", n); end
      observe_frame(300, -1, -1, 0, 4, d);
      n_checks++; if (d !== 90) begin n_fail++; $display("FAIL en_drop_frame_done: got %0d want 90", d); end
      n_checks++; if (nwords !== 3 || words[2] !== 24'h778899) begin n_fail++; $display("FAIL en_drop_words: n %0d w2 %h want 3 778899", nwords, words[2]); end
      rd_cnt = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (pix_rd) rd_cnt++;
      end
      n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL en_drop_no_restart: pix_rd %0d want 0", rd_cnt); end
   endtask

   task automatic test_mid_reset();
      int n, d;
      enable = 1'b1;
      wait_rd(1100, n);
      n_checks++; if (n !== 910) begin n_fail++; $display("FAIL mrst_frame_start: got %0d want 910", n); end
      tx_ready = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== 24'h112233) begin n_fail++; $display("FAIL mrst_stalled_word: valid %b data %h want 1 112233", tx_valid, tx_data); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mrst_outputs: valid %b busy %b want 0 0", tx_valid, busy); end
      n_checks++; if (tx_data !== 24'h0 || pix_addr !== 2'd0 || pix_rd !== 1'b0) begin n_fail++; $display("FAIL mrst_regs: data %h addr %0d rd %b want 000000 0 0", tx_data, pix_addr, pix_rd); end
      rst = 1'b0; tx_ready = 1'b1;
      wait_rd(1100, n);
      n_checks++; if (n !== 1000) begin n_fail++; $display("FAIL mrst_tick_restart: got %0d want 1000", n); end
      observe_frame(300, -1, -1, 0, -1, d);
      n_checks++; if (d !== 90 || nwords !== 3) begin n_fail++; $display("FAIL mrst_frame: done %0d words %0d want 90 3", d, nwords); end
   endtask

`ifdef WS2812_BRIGHTNESS_EN
   task automatic test_brightness();
      int n, d;
      mem[0] = 24'hFF8002;
      brightness = 8'd127;
      wait_rd(1100, n);
      observe_frame(300, -1, -1, 0, -1, d);
      n_checks++; if (words[0] !== 24'h7F4001) begin n_fail++; $display("FAIL dim127_word0: got %h want 7f4001", words[0]); end
      n_checks++; if (words[1] !== 24'h222A33) begin n_fail++; $display("FAIL dim127_word1: got %h want 222a33", words[1]); end
      brightness = 8'd255;
      wait_rd(1100, n);
      observe_frame(300, -1, -1, 0, -1, d);
      n_checks++; if (words[0] !== 24'hFF8002) begin n_fail++; $display("FAIL dim255_word0: got %h want ff8002", words[0]); end
      n_checks++; if (words[2] !== 24'h778899) begin n_fail++; $display("FAIL dim255_word2: got %h want 778899", words[2]); end
      mem[0] = 24'h112233;
   endtask
`endif

   initial begin
      mem[0] = 24'h112233;
      mem[1] = 24'h445566;
      mem[2] = 24'h778899;
      test_reset();
      test_nominal();
      test_backpressure();
      test_overrun();
      test_enable();
      test_mid_reset();
`ifdef WS2812_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_ctrl.md
# ws2812_frame_ctrl

Frame scheduler for the WS2812 LED string. Each frame period it walks a pixel memory from LED 0 to NUM_LEDS-1 and feeds one 24-bit GRB word per LED to the ws2812_tx serializer over a valid/ready handshake. After the last word has been fully shifted out, it holds the line idle for the latch gap. It sits between the pixel RAM (written by animation logic) and ws2812_tx inside ledstring.

## Interface
- NUM_LEDS, 8: LEDs per frame, ≥1.
- CLK_HZ, 48_000_000: clk frequency.
- FRAME_HZ, 60: frame tick rate.
- LATCH_US, 80: latch gap after the last bit, in µs.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  frames start only while high.
- pix_rd  out  1  pixel read strobe, one cycle.
- pix_addr  out  AW=max(1,$clog2(NUM_LEDS))  pixel index.
- pix_data  in  24  GRB word, valid exactly 1 cycle after pix_rd.
- tx_data  out  24  word to ws2812_tx.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  ws2812_tx accepts the word when valid&&ready.
- tx_idle  in  1  ws2812_tx shift register empty, line low.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of LATCH.
- overrun  out  1  one-cycle pulse when a tick is dropped.
- brightness  in  8  global dimming; present only with WS2812_BRIGHTNESS_EN.

## Operation
- Reset values: all outputs 0, pix_addr=0, state IDLE, tick counter 0.
- Tick counter: counts 0..FRAME_CYCLES-1, where FRAME_CYCLES=CLK_HZ/FRAME_HZ. It raises tick on the wrap cycle. It free-runs independent of state and enable.
- FSM states: IDLE, FETCH, LOAD, SEND, DRAIN, LATCH.
  - IDLE: on tick && enable → FETCH with pix_addr=0. A tick with enable=0 is ignored silently.
  - FETCH: pix_rd=1 for one cycle → LOAD.
  - LOAD: register pix_data (scaled if configured) into tx_data; tx_valid=1 → SEND.
  - SEND: hold tx_data and tx_valid stable until tx_valid&&tx_ready. Then:
    - if pix_addr==NUM_LEDS-1 → DRAIN;
    - otherwise pix_addr+1 → FETCH.
  - DRAIN: tx_valid=0; wait for tx_idle=1 → LATCH, clearing the latch counter.
  - LATCH: count LATCH_CYCLES=(CLK_HZ/1_000_000)*LATCH_US cycles, then pulse frame_done for one cycle → IDLE.
- A tick arriving in any state other than IDLE pulses overrun in the same cycle and is dropped, not queued.
- enable falling mid-frame does not abort; the current frame completes.
- rst mid-frame: the next cycle matches the reset values. tx_valid drops immediately; a partially shifted word is the serializer's concern.
- pix_addr never exceeds NUM_LEDS-1. It wraps to 0 only at FETCH entry from IDLE.

## Timing
- Tick → pix_rd: 1 cycle (tick in IDLE, FETCH on the next cycle).
- pix_rd → tx_valid: 2 cycles (LOAD registers, SEND presents).
- Minimum per-LED overhead when tx_ready is already high: 3 cycles (FETCH, LOAD, SEND).
- tx_data changes only in LOAD; it is never modified while tx_valid=1.
- Last handshake → frame_done: DRAIN wait + LATCH_CYCLES + 1 cycles.

## Configuration
- WS2812_BRIGHTNESS_EN defined:
  - brightness port exists;
  - in LOAD, each 8-bit channel c becomes (c*(brightness+1))>>8;
  - brightness=255 is identity and brightness=0 gives 0;
  - brightness is sampled in LOAD only.
- Undefined: no port; pix_data passes to tx_data unchanged.

## Structure
- Package ws2812_pkg holds:
  - state enum;
  - PIX_W=24;
  - functions frame_cycles(CLK_HZ,FRAME_HZ) and latch_cycles(CLK_HZ,LATCH_US).
- Sub-module ws2812_dim: combinational per-channel scaler, instantiated three times under WS2812_BRIGHTNESS_EN.
- Tick counter and FSM stay in this module.

## Test plan
Bench parameters: NUM_LEDS=3, CLK_HZ=1_000_000, FRAME_HZ=1000 (1000-cycle frame), LATCH_US=80 (80 cycles). Pixel RAM model with 1-cycle latency holds 0x112233, 0x445566, 0x778899.
- Reset: hold rst=1 for 5 cycles → all outputs 0, busy=0. Release → first pix_rd 1 cycle after the cycle-999 tick.
- Nominal frame with tx_ready=1 and tx_idle=1 after the last word:
  - accepted words are 0x112233, 0x445566, 0x778899 in order;
  - frame_done pulses 81 cycles after DRAIN entry;
  - busy falls with IDLE.
- Backpressure: tx_ready=0 for 10 cycles on word 1 → tx_data stays 0x445566 and tx_valid stays 1 throughout; no extra pix_rd.
- Overrun: tx_idle held 0 for 1200 cycles → one overrun pulse at the next tick; no second frame starts until IDLE; the next tick after IDLE starts a frame.
- enable=0 at a tick → no pix_rd and no overrun. enable dropped mid-frame → the frame still finishes with frame_done.
- WS2812_BRIGHTNESS_EN with brightness=127 and pixel 0xFF8002 → tx_data 0x7F4001. With brightness=255 → the word is unchanged.
